// File: rtl/saber_pkg.sv
// Shared constants and types for the saber game-state register bank.
// Master identities and well-known register indices used by the game logic.
package saber_pkg;

    localparam int NUM_REGS_DEF = 64;
    localparam int ADDR_W_DEF   = 6;
    localparam int DATA_W_DEF   = 32;

    typedef enum logic {
        M_CPU = 1'b0,
        M_HW  = 1'b1
    } master_e;

    localparam int REG_POS_X       = 0;
    localparam int REG_POS_Y       = 1;
    localparam int REG_SABER_STATE = 2;

endpackage

// File: rtl/saber_reg_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. Bit 0 of req/gnt is the CPU and bit 1 is the HW master.
// The master that won most recently loses the next conflict. No grant is issued while reset is high.
module rr_arb2
    import saber_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    master_e last_winner;

    always_comb begin
        gnt = 2'b00;
        if (!reset) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (last_winner == M_HW) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    // After reset the HW master counts as the last winner, so the CPU wins the first conflict.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_winner <= M_HW;
        end else if (gnt[0]) begin
            last_winner <= M_CPU;
        end else if (gnt[1]) begin
            last_winner <= M_HW;
        end
    end

endmodule

// File: rtl/saber_reg_arbiter.sv
// Game-state register bank shared by the Avalon CPU and a hardware master. It services one access per cycle.
// Optional conflict counter port STAT_CONFLICTS is built when SABER_ARB_STATS_EN is defined.
module saber_reg_arbiter
    import saber_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       AVL_CS,
    input  logic                       AVL_READ,
    input  logic                       AVL_WRITE,
    input  logic [DATA_W/8-1:0]        AVL_BYTE_EN,
    input  logic [ADDR_W-1:0]          AVL_ADDR,
    input  logic [DATA_W-1:0]          AVL_WRITEDATA,
    output logic [DATA_W-1:0]          AVL_READDATA,
    output logic                       AVL_WAITREQUEST,
    input  logic                       HW_REQ,
    input  logic                       HW_WE,
    input  logic [DATA_W/8-1:0]        HW_BYTE_EN,
    input  logic [ADDR_W-1:0]          HW_ADDR,
    input  logic [DATA_W-1:0]          HW_WDATA,
    output logic                       HW_GNT,
    output logic [DATA_W-1:0]          HW_RDATA,
    output logic                       HW_RVALID,
    output logic [NUM_REGS*DATA_W-1:0] EXPORT_DATA
`ifdef SABER_ARB_STATS_EN
    ,
    output logic [15:0]                STAT_CONFLICTS
`endif
);

    localparam int BE_W = DATA_W / 8;

    // Handshake: each master holds its request (cpu_req / HW_REQ) and its fields steady until
    // the cycle it is granted. The grant is a ready pulse. The access completes at the edge ending that cycle.
    logic              cpu_req;
    logic              cpu_gnt;
    logic              hw_gnt;
    logic [1:0]        gnt;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [BE_W-1:0]   acc_be;
    logic [DATA_W-1:0] acc_wdata;
    logic [DATA_W-1:0] cpu_rd_word;
    logic [DATA_W-1:0] hw_rd_word;
    logic [DATA_W-1:0] bank [NUM_REGS];

    assign cpu_req = AVL_CS & (AVL_READ | AVL_WRITE);

    rr_arb2 u_arb (
        .clk   (CLK),
        .reset (RESET),
        .req   ({HW_REQ, cpu_req}),
        .gnt   (gnt)
    );

    assign cpu_gnt         = gnt[0];
    assign hw_gnt          = gnt[1];
    assign HW_GNT          = hw_gnt;
    assign AVL_WAITREQUEST = cpu_req & ~cpu_gnt;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < NUM_REGS;
    endfunction

    // The arbiter grants one master at most, so these fields come from that master.
    always_comb begin
        acc_we    = hw_gnt & HW_WE;
        acc_addr  = HW_ADDR;
        acc_be    = HW_BYTE_EN;
        acc_wdata = HW_WDATA;
        if (cpu_gnt) begin
            acc_we    = AVL_WRITE;
            acc_addr  = AVL_ADDR;
            acc_be    = AVL_BYTE_EN;
            acc_wdata = AVL_WRITEDATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                bank[i] <= '0;
            end
        end else if (acc_we && in_range(acc_addr)) begin
            for (int k = 0; k < BE_W; k++) begin
                if (acc_be[k]) begin
                    bank[acc_addr][k*8 +: 8] <= acc_wdata[k*8 +: 8];
                end
            end
        end
    end

    assign cpu_rd_word = in_range(AVL_ADDR) ? bank[AVL_ADDR] : '0;
    assign hw_rd_word  = in_range(HW_ADDR)  ? bank[HW_ADDR]  : '0;

    // When AVL_READ and AVL_WRITE are both high the access is a write, so no read data is returned.
    assign AVL_READDATA = (cpu_gnt & ~AVL_WRITE) ? cpu_rd_word : '0;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            HW_RDATA  <= '0;
            HW_RVALID <= 1'b0;
        end else begin
            HW_RVALID <= hw_gnt & ~HW_WE;
            if (hw_gnt & ~HW_WE) begin
                HW_RDATA <= hw_rd_word;
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_export
        assign EXPORT_DATA[i*DATA_W +: DATA_W] = bank[i];
    end

`ifdef SABER_ARB_STATS_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            STAT_CONFLICTS <= '0;
        end else if (cpu_req && HW_REQ && STAT_CONFLICTS != 16'hFFFF) begin
            STAT_CONFLICTS <= STAT_CONFLICTS + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_saber_reg_arbiter.sv
// Self-checking bench for saber_reg_arbiter using directed scenarios, randomized traffic and a bank-level reference model.
// Build with SABER_ARB_STATS_EN defined to also cover the conflict counter.
module tb_saber_reg_arbiter;
    import saber_pkg::*;

    localparam int NR = 64;
    localparam int AW = 6;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic             CLK;
    logic             RESET;
    logic             AVL_CS;
    logic             AVL_READ;
    logic             AVL_WRITE;
    logic [BW-1:0]    AVL_BYTE_EN;
    logic [AW-1:0]    AVL_ADDR;
    logic [DW-1:0]    AVL_WRITEDATA;
    logic [DW-1:0]    AVL_READDATA;
    logic             AVL_WAITREQUEST;
    logic             HW_REQ;
    logic             HW_WE;
    logic [BW-1:0]    HW_BYTE_EN;
    logic [AW-1:0]    HW_ADDR;
    logic [DW-1:0]    HW_WDATA;
    logic             HW_GNT;
    logic [DW-1:0]    HW_RDATA;
    logic             HW_RVALID;
    logic [NR*DW-1:0] EXPORT_DATA;
`ifdef SABER_ARB_STATS_EN
    logic [15:0]      STAT_CONFLICTS;
`endif

    saber_reg_arbiter dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .AVL_CS          (AVL_CS),
        .AVL_READ        (AVL_READ),
        .AVL_WRITE       (AVL_WRITE),
        .AVL_BYTE_EN     (AVL_BYTE_EN),
        .AVL_ADDR        (AVL_ADDR),
        .AVL_WRITEDATA   (AVL_WRITEDATA),
        .AVL_READDATA    (AVL_READDATA),
        .AVL_WAITREQUEST (AVL_WAITREQUEST),
        .HW_REQ          (HW_REQ),
        .HW_WE           (HW_WE),
        .HW_BYTE_EN      (HW_BYTE_EN),
        .HW_ADDR         (HW_ADDR),
        .HW_WDATA        (HW_WDATA),
        .HW_GNT          (HW_GNT),
        .HW_RDATA        (HW_RDATA),
        .HW_RVALID       (HW_RVALID),
`ifdef SABER_ARB_STATS_EN
        .STAT_CONFLICTS  (STAT_CONFLICTS),
`endif
        .EXPORT_DATA     (EXPORT_DATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Reference model: bank contents, the master that was served last, and the pending HW read result.
    logic [DW-1:0] m_bank [NR];
    master_e       m_last;
    logic          m_rvalid;
    logic [DW-1:0] m_rdata;
    int            m_conf;
    logic          e_cpu_gnt;
    logic          e_hw_gnt;
    logic          e_wait;
    logic [DW-1:0] e_avl_rdata;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] mask = '0;
        for (int b = 0; b < BW; b++) begin
            if (be[b]) mask = mask | (DW'(8'hFF) << (8 * b));
        end
        return (old & ~mask) | (wd & mask);
    endfunction

    task automatic cpu_set(input logic rd, input logic wr, input logic [AW-1:0] a,
                           input logic [BW-1:0] be, input logic [DW-1:0] wd);
        AVL_CS = rd | wr; AVL_READ = rd; AVL_WRITE = wr;
        AVL_ADDR = a; AVL_BYTE_EN = be; AVL_WRITEDATA = wd;
    endtask

    task automatic hw_set(input logic rq, input logic we, input logic [AW-1:0] a,
                          input logic [BW-1:0] be, input logic [DW-1:0] wd);
        HW_REQ = rq; HW_WE = we; HW_ADDR = a; HW_BYTE_EN = be; HW_WDATA = wd;
    endtask

    task automatic idle();
        cpu_set(0, 0, '0, '0, '0);
        hw_set(0, 0, '0, '0, '0);
    endtask

    // Work out from the model who should be served this cycle. Inputs are sampled mid-cycle.
    task automatic eval();
        logic cr;
        @(negedge CLK);
        cr = AVL_CS & (AVL_READ | AVL_WRITE);
        e_cpu_gnt = 1'b0;
        e_hw_gnt  = 1'b0;
        if (!RESET) begin
            if (cr && HW_REQ) begin
                if (m_last == M_HW) e_cpu_gnt = 1'b1;
                else                e_hw_gnt  = 1'b1;
            end else begin
                e_cpu_gnt = cr;
                e_hw_gnt  = HW_REQ;
            end
        end
        e_wait      = cr & ~e_cpu_gnt;
        e_avl_rdata = (e_cpu_gnt && !AVL_WRITE) ? m_bank[AVL_ADDR] : '0;
    endtask

    task automatic commit();
        if (RESET) begin
            for (int r = 0; r < NR; r++) m_bank[r] = '0;
            m_last = M_HW; m_rvalid = 1'b0; m_rdata = '0; m_conf = 0;
        end else begin
            if (AVL_CS && (AVL_READ || AVL_WRITE) && HW_REQ && m_conf < 65535) m_conf++;
            m_rvalid = 1'b0;
            if (e_cpu_gnt) begin
                m_last = M_CPU;
                if (AVL_WRITE) m_bank[AVL_ADDR] = merge(m_bank[AVL_ADDR], AVL_WRITEDATA, AVL_BYTE_EN);
            end
            if (e_hw_gnt) begin
                m_last = M_HW;
                if (HW_WE) m_bank[HW_ADDR] = merge(m_bank[HW_ADDR], HW_WDATA, HW_BYTE_EN);
                else begin
                    m_rdata = m_bank[HW_ADDR];
                    m_rvalid = 1'b1;
                end
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1; idle();
        eval(); commit();
        eval();
        checks++; if (EXPORT_DATA !== '0) begin errors++; $display("FAIL reset_bank: got nonzero image, expected all 0"); end
        checks++; if (HW_RVALID !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", HW_RVALID); end
        checks++; if (HW_RDATA !== '0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", HW_RDATA); end
        commit();
        cpu_set(0, 1, 5, 4'hF, 32'h1111_2222); hw_set(1, 1, 6, 4'hF, 32'h3333_4444);
        eval();
        checks++; if (AVL_WAITREQUEST !== 1'b1) begin errors++; $display("FAIL reset_wait: got %b expected 1", AVL_WAITREQUEST); end
        checks++; if (HW_GNT !== 1'b0) begin errors++; $display("FAIL reset_hw_gnt: got %b expected 0", HW_GNT); end
        commit();
        RESET = 1'b0; idle();
        eval(); commit();
    endtask

    task automatic test_cpu_writes();
        cpu_set(0, 1, REG_POS_Y, 4'hF, 32'hDEAD_BEEF);
        eval();
        checks++; if (AVL_WAITREQUEST !== 1'b0) begin errors++; $display("FAIL cpu_wr1_wait: got %b expected 0", AVL_WAITREQUEST); end
        commit();
        cpu_set(0, 1, REG_POS_Y, 4'h4, 32'h00AA_0000);
        eval();
        checks++; if (AVL_WAITREQUEST !== 1'b0) begin errors++; $display("FAIL cpu_wr2_wait: got %b expected 0", AVL_WAITREQUEST); end
        commit();
        cpu_set(1, 0, REG_POS_Y, 4'hF, '0);
        eval();
        checks++; if (EXPORT_DATA[63:32] !== 32'hDEAA_BEEF) begin errors++; $display("FAIL cpu_export: got %h expected deaabeef", EXPORT_DATA[63:32]); end
        checks++; if (AVL_READDATA !== 32'hDEAA_BEEF) begin errors++; $display("FAIL cpu_readback: got %h expected deaabeef", AVL_READDATA); end
        commit();
        idle();
    endtask

    task automatic test_first_conflict();
        RESET = 1'b1; idle(); eval(); commit();
        RESET = 1'b0;
        cpu_set(0, 1, REG_POS_X, 4'hF, 32'h5);
        hw_set(1, 0, REG_POS_X, 4'hF, '0);
        eval();
        checks++; if (AVL_WAITREQUEST !== 1'b0) begin errors++; $display("FAIL conflict_c0_wait: got %b expected 0", AVL_WAITREQUEST); end
        checks++; if (HW_GNT !== 1'b0) begin errors++; $display("FAIL conflict_c0_hw_gnt: got %b expected 0", HW_GNT); end
        commit();
        cpu_set(0, 0, '0, '0, '0);
        eval();
        checks++; if (HW_GNT !== 1'b1) begin errors++; $display("FAIL conflict_c1_hw_gnt: got %b expected 1", HW_GNT); end
        commit();
        idle();
        eval();
        checks++; if (HW_RVALID !== 1'b1) begin errors++; $display("FAIL conflict_c2_rvalid: got %b expected 1", HW_RVALID); end
        checks++; if (HW_RDATA !== 32'h5) begin errors++; $display("FAIL conflict_c2_rdata: got %h expected 5", HW_RDATA); end
        commit();
    endtask

    task automatic test_contention();
        logic prev_hw = 1'b0;
        int conf0 = m_conf;
        int longest_wait = 0;
        int cur_wait = 0;
        cpu_set(1, 0, 7, 4'hF, '0);
        hw_set(1, 1, 8, 4'hF, 32'hCAFE_0000);
        for (int k = 0; k < 10; k++) begin
            eval();
            checks++; if (HW_GNT !== e_hw_gnt) begin errors++; $display("FAIL contention_hw_gnt[%0d]: got %b expected %b", k, HW_GNT, e_hw_gnt); end
            checks++; if (AVL_WAITREQUEST !== e_wait) begin errors++; $display("FAIL contention_wait[%0d]: got %b expected %b", k, AVL_WAITREQUEST, e_wait); end
            checks++; if (AVL_READDATA !== e_avl_rdata) begin errors++; $display("FAIL contention_rdata[%0d]: got %h expected %h", k, AVL_READDATA, e_avl_rdata); end
            if (k > 0) begin
                checks++; if (HW_GNT === prev_hw) begin errors++; $display("FAIL contention_alternate[%0d]: got hw_gnt %b twice", k, HW_GNT); end
            end
            cur_wait = AVL_WAITREQUEST ? cur_wait + 1 : 0;
            if (cur_wait > longest_wait) longest_wait = cur_wait;
            prev_hw = HW_GNT;
            commit();
            cpu_set(1, 0, AW'($urandom_range(0, NR - 1)), 4'hF, '0);
            hw_set(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, NR - 1)), 4'hF, $urandom);
        end
        checks++; if (longest_wait > 1) begin errors++; $display("FAIL contention_max_wait: got %0d expected <=1", longest_wait); end
`ifdef SABER_ARB_STATS_EN
        checks++; if (STAT_CONFLICTS !== 16'(conf0 + 10)) begin errors++; $display("FAIL contention_stats: got %0d expected %0d", STAT_CONFLICTS, conf0 + 10); end
`endif
        idle();
        eval(); commit();
    endtask

    task automatic test_zero_be();
        cpu_set(0, 1, REG_SABER_STATE, 4'hF, 32'h1234);
        eval(); commit();
        cpu_set(0, 1, REG_SABER_STATE, 4'h0, 32'hFFFF_FFFF);
        eval();
        checks++; if (AVL_WAITREQUEST !== 1'b0) begin errors++; $display("FAIL zero_be_cpu_wait: got %b expected 0", AVL_WAITREQUEST); end
        commit();
        cpu_set(0, 0, '0, '0, '0);
        hw_set(1, 1, REG_SABER_STATE, 4'h0, 32'hFFFF_FFFF);
        eval();
        checks++; if (HW_GNT !== 1'b1) begin errors++; $display("FAIL zero_be_hw_gnt: got %b expected 1", HW_GNT); end
        checks++; if (EXPORT_DATA[2*DW +: DW] !== 32'h1234) begin errors++; $display("FAIL zero_be_cpu_value: got %h expected 1234", EXPORT_DATA[2*DW +: DW]); end
        commit();
        idle();
        eval();
        checks++; if (EXPORT_DATA[2*DW +: DW] !== 32'h1234) begin errors++; $display("FAIL zero_be_hw_value: got %h expected 1234", EXPORT_DATA[2*DW +: DW]); end
        commit();
    endtask

    task automatic test_reset_mid();
        cpu_set(0, 1, 3, 4'hF, 32'hFF);
        eval(); commit();
        cpu_set(0, 0, '0, '0, '0);
        hw_set(1, 0, 3, 4'hF, '0);
        RESET = 1'b1;
        eval();
        checks++; if (HW_GNT !== 1'b0) begin errors++; $display("FAIL mid_reset_hw_gnt: got %b expected 0", HW_GNT); end
        checks++; if (EXPORT_DATA[3*DW +: DW] !== 32'hFF) begin errors++; $display("FAIL mid_reset_pre_value: got %h expected ff", EXPORT_DATA[3*DW +: DW]); end
        commit();
        eval();
        checks++; if (EXPORT_DATA !== '0) begin errors++; $display("FAIL mid_reset_bank: got nonzero image, expected all 0"); end
        checks++; if (HW_RVALID !== 1'b0) begin errors++; $display("FAIL mid_reset_rvalid: got %b expected 0", HW_RVALID); end
        checks++; if (HW_GNT !== 1'b0) begin errors++; $display("FAIL mid_reset_hw_gnt2: got %b expected 0", HW_GNT); end
        commit();
        RESET = 1'b0;
        eval();
        checks++; if (HW_GNT !== 1'b1) begin errors++; $display("FAIL post_reset_hw_gnt: got %b expected 1", HW_GNT); end
        commit();
        idle();
        eval();
        checks++; if (HW_RVALID !== 1'b1 || HW_RDATA !== '0) begin errors++; $display("FAIL post_reset_read: got %b/%h expected 1/0", HW_RVALID, HW_RDATA); end
        commit();
    endtask

    task automatic test_random();
        bit cpu_busy = 0;
        bit hw_busy = 0;
        int bad;
        int op;
        for (int i = 0; i < 400; i++) begin
            if (!cpu_busy) begin
                if ($urandom_range(0, 3) != 0) begin
                    op = $urandom_range(0, 2);
                    cpu_set(op != 1, op != 0, AW'($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, NR - 1)),
                            BW'($urandom_range(0, 15)), $urandom);
                    cpu_busy = 1;
                end else cpu_set(0, 0, '0, '0, '0);
            end
            if (!hw_busy) begin
                if ($urandom_range(0, 3) != 0) begin
                    hw_set(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, NR - 1)),
                           BW'($urandom_range(0, 15)), $urandom);
                    hw_busy = 1;
                end else hw_set(0, 0, '0, '0, '0);
            end
            eval();
            checks++; if (HW_GNT !== e_hw_gnt) begin errors++; $display("FAIL rand_hw_gnt[%0d]: got %b expected %b", i, HW_GNT, e_hw_gnt); end
            checks++; if (AVL_WAITREQUEST !== e_wait) begin errors++; $display("FAIL rand_wait[%0d]: got %b expected %b", i, AVL_WAITREQUEST, e_wait); end
            checks++; if (AVL_READDATA !== e_avl_rdata) begin errors++; $display("FAIL rand_avl_rdata[%0d]: got %h expected %h", i, AVL_READDATA, e_avl_rdata); end
            checks++; if (HW_RVALID !== m_rvalid) begin errors++; $display("FAIL rand_rvalid[%0d]: got %b expected %b", i, HW_RVALID, m_rvalid); end
            checks++; if (HW_RDATA !== m_rdata) begin errors++; $display("FAIL rand_hw_rdata[%0d]: got %h expected %h", i, HW_RDATA, m_rdata); end
            bad = 0;
            for (int r = 0; r < NR; r++) if (EXPORT_DATA[r*DW +: DW] !== m_bank[r]) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL rand_export[%0d]: got %0d differing registers expected 0", i, bad); end
            commit();
            if (e_cpu_gnt) cpu_busy = 0;
            if (e_hw_gnt) hw_busy = 0;
        end
        idle();
        eval(); commit();
    endtask

`ifdef SABER_ARB_STATS_EN
    task automatic test_stats_saturation();
        cpu_set(1, 0, 0, 4'hF, '0);
        hw_set(1, 0, 1, 4'hF, '0);
        for (int k = 0; k < 70000; k++) begin
            eval(); commit();
        end
        checks++; if (STAT_CONFLICTS !== 16'hFFFF) begin errors++; $display("FAIL stats_saturate: got %h expected ffff", STAT_CONFLICTS); end
        eval(); commit();
        checks++; if (STAT_CONFLICTS !== 16'(m_conf)) begin errors++; $display("FAIL stats_no_wrap: got %h expected %h", STAT_CONFLICTS, 16'(m_conf)); end
        idle();
        eval(); commit();
    endtask
`endif

    initial begin
        RESET = 1'b1;
        idle();
        @(posedge CLK);
        #1;
        test_reset();
        test_cpu_writes();
        test_first_conflict();
        test_contention();
        test_zero_be();
        test_reset_mid();
        test_random();
`ifdef SABER_ARB_STATS_EN
        test_stats_saturation();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
